// File: rtl/ram_arbiter2.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two requesters.
// After every reset the whole RAM is first cleared to INIT_VAL (when CLEAR = 1).
module ram_arbiter2 #(
  parameter int              AW       = 5,
  parameter int              DW       = 8,
  parameter logic [DW-1:0]   INIT_VAL = '0,
  parameter bit              CLEAR    = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  output logic          busy,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] a0,
  input  logic [DW-1:0] din0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] dout0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] a1,
  input  logic [DW-1:0] din1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] dout1,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic {S_CLEAR, S_SERVE} state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic          last;
  logic          serve;

  // Grants are combinational in SERVE; on contention the port not served last wins.
  assign serve = (state == S_SERVE) && !reset;
  assign gnt0  = serve && req0 && (!req1 || last);
  assign gnt1  = serve && req1 && (!req0 || !last);
  assign busy  = (state == S_CLEAR);

  // Both clients see the raw RAM output; rvalid qualifies which one owns it.
  assign dout0 = ram_dout;
  assign dout1 = ram_dout;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    ram_a   = a0;
    ram_din = din0;
    ram_we  = 1'b0;
    if (state == S_CLEAR) begin
      ram_a   = cnt;
      ram_din = INIT_VAL;
      ram_we  = !reset;
    end else if (gnt1) begin
      ram_a   = a1;
      ram_din = din1;
      ram_we  = we1;
    end else if (gnt0) begin
      ram_we  = we0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR ? S_CLEAR : S_SERVE;
      cnt     <= '0;
      last    <= 1'b1;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          cnt     <= cnt + 1'b1;
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          if (cnt == {AW{1'b1}}) state <= S_SERVE;
        end
        S_SERVE: begin
          if (gnt0) last <= 1'b0;
          if (gnt1) last <= 1'b1;
          rvalid0 <= gnt0 && !we0;
          rvalid1 <= gnt1 && !we1;
        end
        default: state <= S_SERVE;
      endcase
    end
  end

endmodule
